karatsuba_preadd: RTL and testbench
===================================

# karatsuba_preadd

- Pipelined operand pre-adder directly upstream of `foldKaratsuba`.
- Accepts a 128-bit X and a 256-bit Y under a valid/ready handshake and splits them into 64-bit limbs.
- Produces the six 65-bit limb sums the folded Karatsuba multiplier consumes, alongside the registered X/Y.
- Two register stages, full throughput, backpressure from the multiplier side.

## Interface
Parameters:
- `LIMB_W`, default 64, limb width. X is 2·LIMB_W bits, Y is 4·LIMB_W bits, sums are LIMB_W+1 bits.

Ports:
- `clock`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream operand pair valid.
- `in_ready`  out  1  block can accept this cycle.
- `X_in`  in  2·LIMB_W  multiplicand; X0 = [L-1:0], X1 = [2L-1:L].
- `Y_in`  in  4·LIMB_W  multiplier; Y0 is the lowest limb through Y3 the highest.
- `out_valid`  out  1  outputs valid.
- `out_ready`  in  1  downstream accepts; tie high for a non-stalling multiplier.
- `X`, `Y`  out  2·L / 4·L  registered operands.
- `X1X0`, `Y1Y0`, `Y2Y0`, `Y2Y1`, `Y3Y0`, `Y3Y1`  out  L+1 each  limb sums, e.g. `Y2Y0` = Y2+Y0.

## Operation
- Transfer occurs on a rising edge with valid=1 and ready=1, on both sides.
- Stage 1 (S1) captures X_in/Y_in on input transfer.
- Between S1 and S2, combinational logic forms the six unsigned sums, zero-extended to L+1 bits. The carry is kept, never truncated.
- Stage 2 (S2) holds the sums plus X/Y and drives `out_valid`.
- Each stage has a valid bit. A stage loads when it is empty or its contents move forward in the same cycle.
  - S2 loads from S1 when `!s2_valid || out_ready`.
  - `in_ready` = `!s1_valid || s1_advance` (combinational path from `out_ready`, unless the macro below is set).
- Stall with `out_valid=1` and `out_ready=0`: S2 outputs stay stable; S1 holds once filled; `in_ready` drops.
- Simultaneous accept and drain in one cycle: both happen; no bubble, no loss.
- Data registers are not reset. Only valid bits and the skid state are reset.
- Reset asserted mid-operation drops all in-flight operands; no partial output is emitted.
- Outputs during and after reset: `out_valid`=0. `in_ready`=1 (0 while `reset` is low). Data outputs are unspecified until the first `out_valid`.

## Timing
- Latency: accepted on edge k, `out_valid` is 1 after edge k+1 (two registers, so visible in cycle k+1), with `out_ready` held high.
- Throughput: one operand pair per cycle while `out_ready`=1.
- Capacity: two pairs in flight without the skid buffer, three with it.
- `out_valid` never falls without a transfer.
- Outputs do not change while `out_valid`=1 and `out_ready`=0.

## Configuration
- `KARATSUBA_PREADD_SKID_EN` defined: a one-entry skid buffer sits in front of S1, and `in_ready` is a registered output.
  - `in_ready` falls one cycle after a stall begins; the single extra beat accepted is held in the skid entry.
  - The skid entry drains into S1 before new input is taken, so order is preserved.
- Undefined: no skid entry; `in_ready` is combinational as described in Operation.
- Latency is identical in both builds.

## Structure
- Shared package `karatsuba_pkg`:
  - `LIMB_W` default.
  - Limb-slice helper constants.
  - Packed struct for the operand/limb-sum bundle, so this block's S2 and the multiplier's input use one type.
- One sub-module, `karatsuba_skid`: the generic one-entry skid register, instantiated only under the macro.
- The adders are inline.

## Test plan
- Single transfer, `out_ready`=1, X=all ones, Y0=9cc6df2b0ee713a2, Y1=1c424d77f1b750a9, Y2=1, Y3=all ones. Response two cycles later:
  - X1X0=1fffffffffffffffe, Y1Y0=0b9092ca3009e644b, Y2Y0=09cc6df2b0ee713a3
  - Y2Y1=01c424d77f1b750aa, Y3Y0=19cc6df2b0ee713a1, Y3Y1=11c424d77f1b750a8
- Back-to-back stream: 16 random pairs on consecutive cycles. Response: 16 consecutive `out_valid` beats, in order, sums matching the model, no bubbles.
- Backpressure: `out_ready`=0 for 5 cycles mid-stream.
  - Outputs stay stable while stalled.
  - `in_ready` falls after S1 fills (one cycle later with the skid buffer).
  - No beat is lost or duplicated after release.
- Carry boundaries: all limbs all-ones gives every sum = 1fffffffffffffffe; all zeros gives every sum = 0.
- Reset mid-flight: pull `reset` low with two pairs in flight. Response:
  - `out_valid` goes to 0 immediately (asynchronous) and stays 0 after release.
  - The next accepted pair appears with the normal latency.
- Alternating `out_ready` 1/0 with continuous `in_valid`: accepted count equals emitted count plus occupancy; ordering is preserved.

Source files
------------

// File: rtl/karatsuba_pkg.sv
// Shared types for the folded Karatsuba datapath: limb geometry and the operand/limb-sum
// bundle that leaves the pre-adder and enters the multiplier.
package karatsuba_pkg;

  localparam int DEFAULT_LIMB_W = 64;
  localparam int X_W            = 2 * DEFAULT_LIMB_W;
  localparam int Y_W            = 4 * DEFAULT_LIMB_W;
  localparam int SUM_W          = DEFAULT_LIMB_W + 1;

  // Limb indices; a limb occupies [idx*LIMB_W +: LIMB_W] of its operand.
  localparam int LIMB_X0 = 0;
  localparam int LIMB_X1 = 1;
  localparam int LIMB_Y0 = 0;
  localparam int LIMB_Y1 = 1;
  localparam int LIMB_Y2 = 2;
  localparam int LIMB_Y3 = 3;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [SUM_W-1:0] x1x0;
    logic [SUM_W-1:0] y1y0;
    logic [SUM_W-1:0] y2y0;
    logic [SUM_W-1:0] y2y1;
    logic [SUM_W-1:0] y3y0;
    logic [SUM_W-1:0] y3y1;
  } preadd_bundle_t;

endpackage

// File: rtl/karatsuba_preadd_if.sv
// Handshake bundle between operand source, pre-adder and multiplier.
// slave = the pre-adder side, master = the source/sink driving it.
interface karatsuba_preadd_if
  import karatsuba_pkg::*;
#(
  parameter int LIMB_W = DEFAULT_LIMB_W
);
  logic                in_valid;
  logic                in_ready;
  logic [2*LIMB_W-1:0] X_in;
  logic [4*LIMB_W-1:0] Y_in;
  logic                out_valid;
  logic                out_ready;
  logic [2*LIMB_W-1:0] X;
  logic [4*LIMB_W-1:0] Y;
  logic [LIMB_W:0]     X1X0;
  logic [LIMB_W:0]     Y1Y0;
  logic [LIMB_W:0]     Y2Y0;
  logic [LIMB_W:0]     Y2Y1;
  logic [LIMB_W:0]     Y3Y0;
  logic [LIMB_W:0]     Y3Y1;

  modport slave (
    input  in_valid, X_in, Y_in, out_ready,
    output in_ready, out_valid, X, Y, X1X0, Y1Y0, Y2Y0, Y2Y1, Y3Y0, Y3Y1
  );

  modport master (
    output in_valid, X_in, Y_in, out_ready,
    input  in_ready, out_valid, X, Y, X1X0, Y1Y0, Y2Y0, Y2Y1, Y3Y0, Y3Y1
  );
endinterface

// File: rtl/karatsuba_skid.sv
// Generic one-entry skid register: in_ready comes straight from a flop, and the one beat
// accepted while the consumer stalls is parked here and replayed first.
module karatsuba_skid #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         full;
  logic [W-1:0] hold;
  logic         park;

  assign park = !full && in_valid && !out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
    end else if (full) begin
      if (out_ready) full <= 1'b0;
    end else if (park) begin
      full <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (park) hold <= in_data;
  end

  // Gated with reset so the source sees not-ready while reset is held.
  assign in_ready  = !full && reset;
  assign out_valid = full || in_valid;
  assign out_data  = full ? hold : in_data;
endmodule

// File: rtl/karatsuba_preadd.sv
// Two-stage operand pre-adder feeding foldKaratsuba: registers X/Y, forms the six limb sums.
// Build option KARATSUBA_PREADD_SKID_EN puts a one-entry skid in front of S1 (registered in_ready).
module karatsuba_preadd
  import karatsuba_pkg::*;
#(
  parameter int LIMB_W = DEFAULT_LIMB_W
) (
  input  logic                clock,
  input  logic                reset,
  karatsuba_preadd_if.slave   bus
);
  localparam int XW = 2 * LIMB_W;
  localparam int YW = 4 * LIMB_W;

  logic          feed_valid;
  logic [XW-1:0] feed_x;
  logic [YW-1:0] feed_y;

  logic          s1_valid;
  logic          s1_take;
  logic          s1_advance;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;

  logic           s2_valid;
  logic           s2_take;
  preadd_bundle_t s2_d;
  preadd_bundle_t s2_q;

  assign s2_take    = !s2_valid || bus.out_ready;
  assign s1_advance = s1_valid && s2_take;
  assign s1_take    = !s1_valid || s1_advance;

`ifdef KARATSUBA_PREADD_SKID_EN
  logic [XW+YW-1:0] feed_data;

  karatsuba_skid #(.W(XW + YW)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({bus.X_in, bus.Y_in}),
    .out_valid (feed_valid),
    .out_ready (s1_take),
    .out_data  (feed_data)
  );

  assign {feed_x, feed_y} = feed_data;
`else
  assign feed_valid   = bus.in_valid;
  assign feed_x       = bus.X_in;
  assign feed_y       = bus.Y_in;
  assign bus.in_ready = reset && s1_take;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) s1_valid <= 1'b0;
    else if (s1_take) s1_valid <= feed_valid;
  end

  always_ff @(posedge clock) begin
    if (s1_take && feed_valid) begin
      s1_x <= feed_x;
      s1_y <= feed_y;
    end
  end

  logic [LIMB_W-1:0] x0, x1, y0, y1, y2, y3;

  assign x0 = s1_x[LIMB_X0*LIMB_W +: LIMB_W];
  assign x1 = s1_x[LIMB_X1*LIMB_W +: LIMB_W];
  assign y0 = s1_y[LIMB_Y0*LIMB_W +: LIMB_W];
  assign y1 = s1_y[LIMB_Y1*LIMB_W +: LIMB_W];
  assign y2 = s1_y[LIMB_Y2*LIMB_W +: LIMB_W];
  assign y3 = s1_y[LIMB_Y3*LIMB_W +: LIMB_W];

  // Sums are one bit wider than a limb so the carry reaches the multiplier intact.
  always_comb begin
    s2_d      = '0;
    s2_d.x    = s1_x;
    s2_d.y    = s1_y;
    s2_d.x1x0 = {1'b0, x1} + {1'b0, x0};
    s2_d.y1y0 = {1'b0, y1} + {1'b0, y0};
    s2_d.y2y0 = {1'b0, y2} + {1'b0, y0};
    s2_d.y2y1 = {1'b0, y2} + {1'b0, y1};
    s2_d.y3y0 = {1'b0, y3} + {1'b0, y0};
    s2_d.y3y1 = {1'b0, y3} + {1'b0, y1};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) s2_valid <= 1'b0;
    else if (s2_take) s2_valid <= s1_valid;
  end

  always_ff @(posedge clock) begin
    if (s1_advance) s2_q <= s2_d;
  end

  assign bus.out_valid = s2_valid;
  assign bus.X         = s2_q.x;
  assign bus.Y         = s2_q.y;
  assign bus.X1X0      = s2_q.x1x0;
  assign bus.Y1Y0      = s2_q.y1y0;
  assign bus.Y2Y0      = s2_q.y2y0;
  assign bus.Y2Y1      = s2_q.y2y1;
  assign bus.Y3Y0      = s2_q.y3y0;
  assign bus.Y3Y1      = s2_q.y3y1;
endmodule

// File: tb/tb_karatsuba_preadd.sv
// Self-checking bench for karatsuba_preadd: directed vector table plus stream, stall,
// alternating-ready and reset sequences, with an in-order scoreboard on the output side.
module tb_karatsuba_preadd;
  import karatsuba_pkg::*;

  typedef logic [$bits(preadd_bundle_t)-1:0] wide_t;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    preadd_bundle_t e;
  } vec_t;

`ifdef KARATSUBA_PREADD_SKID_EN
  localparam int CAP         = 3;
  localparam int READY_STALL = 1;
`else
  localparam int CAP         = 2;
  localparam int READY_STALL = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  karatsuba_preadd_if bus ();

  karatsuba_preadd dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total    = 0;
  int passed   = 0;
  int accepted = 0;
  int emitted  = 0;

  preadd_bundle_t exp_q[$];
  preadd_bundle_t cur_exp;
  preadd_bundle_t held;
  logic           held_valid = 1'b0;

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, required %0d", name, act, exp);
    else passed++;
  endtask

  task automatic chk_b(input string name, input wide_t act, input wide_t exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else passed++;
  endtask

  function automatic preadd_bundle_t cur_out();
    preadd_bundle_t b;
    b.x = bus.X;  b.y = bus.Y;
    b.x1x0 = bus.X1X0; b.y1y0 = bus.Y1Y0; b.y2y0 = bus.Y2Y0;
    b.y2y1 = bus.Y2Y1; b.y3y0 = bus.Y3Y0; b.y3y1 = bus.Y3Y1;
    return b;
  endfunction

  function automatic preadd_bundle_t model(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    preadd_bundle_t b;
    logic [63:0] l [6];
    l[0] = x[63:0];    l[1] = x[127:64];
    l[2] = y[63:0];    l[3] = y[127:64];
    l[4] = y[191:128]; l[5] = y[255:192];
    b.x = x; b.y = y;
    b.x1x0 = 65'(l[1]) + 65'(l[0]);
    b.y1y0 = 65'(l[3]) + 65'(l[2]);
    b.y2y0 = 65'(l[4]) + 65'(l[2]);
    b.y2y1 = 65'(l[4]) + 65'(l[3]);
    b.y3y0 = 65'(l[5]) + 65'(l[2]);
    b.y3y1 = 65'(l[5]) + 65'(l[3]);
    return b;
  endfunction

  function automatic vec_t mk(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                              input logic [64:0] x1x0, input logic [64:0] y1y0,
                              input logic [64:0] y2y0, input logic [64:0] y2y1,
                              input logic [64:0] y3y0, input logic [64:0] y3y1);
    vec_t v;
    v.x = x; v.y = y;
    v.e.x = x; v.e.y = y;
    v.e.x1x0 = x1x0; v.e.y1y0 = y1y0; v.e.y2y0 = y2y0;
    v.e.y2y1 = y2y1; v.e.y3y0 = y3y0; v.e.y3y1 = y3y1;
    return v;
  endfunction

  function automatic logic [X_W-1:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output-side scoreboard: in-order data check and stall stability.
  always @(negedge clock) begin
    if (!reset) begin
      held_valid <= 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(cur_exp);
        accepted++;
      end
      if (held_valid) begin
        chk_i("stall_hold_valid", int'(bus.out_valid), 1);
        chk_b("stall_hold_data", wide_t'(cur_out()), wide_t'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        emitted++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL spurious_beat: out_valid beat %0h with nothing outstanding", wide_t'(cur_out()));
        end else begin
          chk_b("beat_data", wide_t'(cur_out()), wide_t'(exp_q.pop_front()));
        end
      end
      held_valid <= bus.out_valid && !bus.out_ready;
      held       <= cur_out();
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input preadd_bundle_t e);
    logic acc;
    int   n;
    bus.in_valid = 1'b1;
    bus.X_in     = x;
    bus.Y_in     = y;
    cur_exp      = e;
    n            = 0;
    acc          = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = bus.in_ready;
      step();
      n++;
    end
    if (!acc) chk_i("send_timeout", n, 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    x = r128();
    y = {r128(), r128()};
    send(x, y, model(x, y));
  endtask

  // Pipeline assumed empty: accept on edge k, out_valid visible only after edge k+1.
  task automatic latency_check(input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input preadd_bundle_t e);
    bus.in_valid = 1'b1;
    bus.X_in     = x;
    bus.Y_in     = y;
    cur_exp      = e;
    step();
    bus.in_valid = 1'b0;
    chk_i("latency_edge_k", int'(bus.out_valid), 0);
    step();
    chk_i("latency_edge_k1", int'(bus.out_valid), 1);
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    step();
    chk_i("drain_empty", exp_q.size(), 0);
    chk_i("drain_balance", emitted, accepted);
  endtask

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int em0;
    int acc0;
    int bubbles;
    logic [X_W-1:0] rx;
    logic [Y_W-1:0] ry;

    vecs[0] = mk({128{1'b1}},
                 {64'hffffffffffffffff, 64'h1, 64'h1c424d77f1b750a9, 64'h9cc6df2b0ee713a2},
                 65'h1fffffffffffffffe, 65'h0b9092ca3009e644b, 65'h09cc6df2b0ee713a3,
                 65'h01c424d77f1b750aa, 65'h19cc6df2b0ee713a1, 65'h11c424d77f1b750a8);
    vecs[1] = mk({128{1'b1}}, {256{1'b1}},
                 65'h1fffffffffffffffe, 65'h1fffffffffffffffe, 65'h1fffffffffffffffe,
                 65'h1fffffffffffffffe, 65'h1fffffffffffffffe, 65'h1fffffffffffffffe);
    vecs[2] = mk('0, '0, 65'h0, 65'h0, 65'h0, 65'h0, 65'h0, 65'h0);
    vecs[3] = mk({64'd2, 64'd1}, {64'd4, 64'd3, 64'd2, 64'd1},
                 65'd3, 65'd3, 65'd4, 65'd5, 65'd5, 65'd6);
    vecs[4] = mk({64'h1, 64'hffffffffffffffff},
                 {64'h8000000000000000, 64'h8000000000000000, 64'h7fffffffffffffff, 64'h1},
                 65'h10000000000000000, 65'h08000000000000000, 65'h08000000000000001,
                 65'h0ffffffffffffffff, 65'h08000000000000001, 65'h0ffffffffffffffff);

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.X_in      = '0;
    bus.Y_in      = '0;
    bus.out_ready = 1'b1;
    cur_exp       = '0;
    repeat (3) step();
    chk_i("reset_out_valid", int'(bus.out_valid), 0);
    chk_i("reset_in_ready", int'(bus.in_ready), 0);
    reset = 1'b1;
    #1;
    chk_i("post_reset_in_ready", int'(bus.in_ready), 1);
    chk_i("post_reset_out_valid", int'(bus.out_valid), 0);
    step();

    // Directed vectors with hand-computed sums, one at a time.
    for (int i = 0; i < 5; i++) begin
      latency_check(vecs[i].x, vecs[i].y, vecs[i].e);
      step();
      step();
    end
    chk_i("directed_count", emitted, 5);

    // Back-to-back stream of 16 pairs, no bubbles expected.
    em0 = emitted;
    bubbles = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send_rand();
      end
      begin
        repeat (3) @(negedge clock);
        for (int i = 0; i < 16; i++) begin
          if (!bus.out_valid) bubbles++;
          @(negedge clock);
        end
      end
    join
    drain();
    chk_i("stream_no_bubble", bubbles, 0);
    chk_i("stream_count", emitted - em0, 16);

    // Five-cycle stall mid-stream.
    em0 = emitted;
    fork
      begin
        for (int i = 0; i < 10; i++) send_rand();
      end
      begin
        repeat (3) step();
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk_i("stall_first_in_ready", int'(bus.in_ready), READY_STALL);
        repeat (4) step();
        chk_i("stall_late_in_ready", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk_i("stall_count", emitted - em0, 10);

    // Alternating out_ready with continuous in_valid.
    em0  = emitted;
    acc0 = accepted;
    fork
      begin
        for (int i = 0; i < 12; i++) send_rand();
      end
      begin
        for (int c = 0; c < 30; c++) begin
          bus.out_ready = (c % 2) == 1;
          if (c == 15) begin
            @(negedge clock);
            chk_i("alt_occupancy", int'((accepted - emitted) <= CAP), 1);
          end
          step();
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk_i("alt_accepted", accepted - acc0, 12);
    chk_i("alt_emitted", emitted - em0, 12);

    // Reset with two pairs in flight.
    send_rand();
    send_rand();
    #2;
    reset = 1'b0;
    #1;
    chk_i("midreset_out_valid", int'(bus.out_valid), 0);
    chk_i("midreset_in_ready", int'(bus.in_ready), 0);
    exp_q.delete();
    accepted = emitted;
    step();
    step();
    reset = 1'b1;
    step();
    chk_i("after_reset_out_valid0", int'(bus.out_valid), 0);
    step();
    chk_i("after_reset_out_valid1", int'(bus.out_valid), 0);
    em0 = emitted;
    rx = r128();
    ry = {r128(), r128()};
    latency_check(rx, ry, model(rx, ry));
    drain();
    chk_i("after_reset_count", emitted - em0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
